// File: rtl/video_dma_if.sv
// -----------------------------------------------------------------------------
// video_dma_if -- bus bundle for the video DMA block.
//
// Groups every non-clock/non-reset signal of video_dma:
//   CPU register port : cpu_sel_reg, cpu_addr (low byte of 0xFFxx), cpu_wr,
//                       cpu_di, cpu_do (read data)
//   LCD status        : lcd_on, mode (00 hblank, 11 transfer)
//   Source bus        : src_rd, src_addr, src_data (valid one clock after addr)
//   OAM write port    : oam_wr, oam_addr, oam_di
//   VRAM write port   : vram_wr, vram_addr, vram_di
//   Status            : oam_dma_active, cpu_halt
//
// Modports:
//   master : the DMA engine (drives the memory ports and status)
//   slave  : the surrounding system / CPU / memories
// -----------------------------------------------------------------------------
interface video_dma_if;
  logic        cpu_sel_reg;
  logic [7:0]  cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;

  logic        lcd_on;
  logic [1:0]  mode;

  logic        src_rd;
  logic [15:0] src_addr;
  logic [7:0]  src_data;

  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_di;

  logic        vram_wr;
  logic [12:0] vram_addr;
  logic [7:0]  vram_di;

  logic        oam_dma_active;
  logic        cpu_halt;

  modport master (
    input  cpu_sel_reg, cpu_addr, cpu_wr, cpu_di, lcd_on, mode, src_data,
    output cpu_do, src_rd, src_addr, oam_wr, oam_addr, oam_di,
           vram_wr, vram_addr, vram_di, oam_dma_active, cpu_halt
  );

  modport slave (
    output cpu_sel_reg, cpu_addr, cpu_wr, cpu_di, lcd_on, mode, src_data,
    input  cpu_do, src_rd, src_addr, oam_wr, oam_addr, oam_di,
           vram_wr, vram_addr, vram_di, oam_dma_active, cpu_halt
  );
endinterface

// File: rtl/video_dma.sv
// -----------------------------------------------------------------------------
// video_dma -- OAM DMA plus optional general/HBlank VRAM DMA.
//
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : video_dma_if.master (CPU registers, LCD status, source bus,
//           OAM and VRAM write ports, oam_dma_active, cpu_halt)
//
// Registers (CPU address low byte): 0x46 OAM page, 0x51/0x52 source,
// 0x53/0x54 destination, 0x55 VRAM DMA control/status.
//
// Build option: define VIDEO_DMA_HDMA_EN to include the VRAM DMA engine.
// Without it only OAM DMA exists; vram_wr and cpu_halt stay 0 and
// 0x51-0x55 ignore writes and read 0xFF.
// -----------------------------------------------------------------------------
module video_dma #(
  parameter int OAM_BYTES  = 160,
  parameter int OAM_CPB    = 4,
  parameter int HDMA_CPB   = 2,
  parameter int HDMA_BLOCK = 16
) (
  input  logic        clk,
  input  logic        reset,
  video_dma_if.master bus
);

  localparam int              OPW          = $clog2(OAM_CPB);
  localparam logic [OPW-1:0]  OAM_PH_LAST  = OPW'(OAM_CPB - 1);
  localparam logic [OPW-1:0]  OAM_PH_WR    = OPW'(OAM_CPB - 2);
  localparam logic [7:0]      OAM_IDX_LAST = 8'(OAM_BYTES - 1);

  logic wr_s;
  logic wr_oam_s;
  assign wr_s     = bus.cpu_sel_reg & bus.cpu_wr;
  assign wr_oam_s = wr_s & (bus.cpu_addr == 8'h46);

  // ---------------------------------------------------------------------------
  // OAM DMA
  // ---------------------------------------------------------------------------
  logic           oam_active_q;
  logic [7:0]     oam_page_q;
  logic [7:0]     oam_idx_q;
  logic [OPW-1:0] oam_ph_q;

  // OAM DMA sequencer: a page write (re)starts at byte 0 phase 0
  always_ff @(posedge clk) begin
    if (reset) begin
      oam_active_q <= 1'b0;
      oam_page_q   <= 8'h00;
      oam_idx_q    <= 8'h00;
      oam_ph_q     <= '0;
    end else if (wr_oam_s) begin
      oam_active_q <= 1'b1;
      oam_page_q   <= bus.cpu_di;
      oam_idx_q    <= 8'h00;
      oam_ph_q     <= '0;
    end else if (oam_active_q) begin
      if (oam_ph_q == OAM_PH_LAST) begin
        oam_ph_q <= '0;
        if (oam_idx_q == OAM_IDX_LAST) begin
          oam_active_q <= 1'b0;
        end else begin
          oam_idx_q <= oam_idx_q + 8'd1;
        end
      end else begin
        oam_ph_q <= oam_ph_q + OPW'(1);
      end
    end
  end

  // Source data is valid from phase 1 on because the address is held
  // for the whole byte; the write lands in the second-to-last phase.
  logic oam_wr_s;
  assign oam_wr_s = oam_active_q & (oam_ph_q == OAM_PH_WR);

  assign bus.oam_dma_active = oam_active_q;
  assign bus.oam_wr         = oam_wr_s & ~reset;
  assign bus.oam_addr       = oam_active_q ? oam_idx_q : 8'h00;
  assign bus.oam_di         = oam_wr_s ? bus.src_data : 8'h00;

  // VRAM engine's view of the source bus and its 0x55 status byte
  logic        vrd_s;
  logic [15:0] vsrc_s;
  logic [7:0]  hdma_rd_s;

`ifdef VIDEO_DMA_HDMA_EN
  // ---------------------------------------------------------------------------
  // VRAM DMA (general and HBlank)
  // ---------------------------------------------------------------------------
  localparam int              HPW        = $clog2(HDMA_CPB);
  localparam logic [HPW-1:0]  HDMA_PH_LAST = HPW'(HDMA_CPB - 1);
  localparam int              CHUNK_MAX  = (HDMA_BLOCK > 16) ? HDMA_BLOCK : 16;
  localparam int              BCW        = $clog2(CHUNK_MAX);
  localparam logic [BCW-1:0]  GDMA_LAST  = BCW'(15);
  localparam logic [BCW-1:0]  HBLK_LAST  = BCW'(HDMA_BLOCK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GDMA  = 2'd1,
    S_HWAIT = 2'd2,
    S_HCOPY = 2'd3
  } vstate_e;

  vstate_e        state_q,  state_d;
  logic [6:0]     blk_q,    blk_d;     // remaining blocks minus one
  logic [15:0]    src_q,    src_d;
  logic [12:0]    dst_q,    dst_d;
  logic [HPW-1:0] ph_q,     ph_d;
  logic [BCW-1:0] cnt_q,    cnt_d;     // byte index inside the current chunk
  logic           abort_q,  abort_d;
  logic           rdpend_q, rdpend_d;  // source read issued last clock
  logic [7:0]     data_q,   data_d;    // source byte kept across an OAM stall
  logic [1:0]     mode_prev_q;

  logic busy_s, run_s, vwr_s, chunk_end_s, hblank_s, w55_s, abort_now_s;

  assign busy_s      = (state_q == S_GDMA) | (state_q == S_HCOPY);
  // OAM DMA owns the source bus: byte phases freeze while it runs
  assign run_s       = busy_s & ~oam_active_q;
  assign vrd_s       = run_s & (ph_q == '0);
  assign vwr_s       = run_s & (ph_q == HDMA_PH_LAST);
  assign chunk_end_s = vwr_s & (cnt_q == ((state_q == S_GDMA) ? GDMA_LAST : HBLK_LAST));
  assign hblank_s    = ~bus.lcd_on | ((mode_prev_q == 2'b11) & (bus.mode == 2'b00));
  assign w55_s       = wr_s & (bus.cpu_addr == 8'h55);
  assign abort_now_s = abort_q | (w55_s & ~bus.cpu_di[7]);
  assign vsrc_s      = busy_s ? src_q : 16'h0000;
  assign hdma_rd_s   = {(state_q == S_IDLE), blk_q};

  // VRAM DMA next-state: byte engine first, then per-state control
  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    src_d    = src_q;
    dst_d    = dst_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    rdpend_d = vrd_s;
    // The read issued last clock is captured so a stall cannot lose it
    data_d   = rdpend_q ? bus.src_data : data_q;

    if (vwr_s) begin
      ph_d  = '0;
      src_d = src_q + 16'd1;
      dst_d = dst_q + 13'd1;
      cnt_d = chunk_end_s ? '0 : cnt_q + BCW'(1);
    end else if (run_s) begin
      ph_d = ph_q + HPW'(1);
    end else begin
      ph_d = ph_q;
    end

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (wr_s) begin
          case (bus.cpu_addr)
            8'h51: src_d[15:8] = bus.cpu_di;
            8'h52: src_d[7:0]  = {bus.cpu_di[7:4], 4'h0};
            8'h53: dst_d[12:8] = bus.cpu_di[4:0];
            8'h54: dst_d[7:0]  = {bus.cpu_di[7:4], 4'h0};
            8'h55: begin
              blk_d   = bus.cpu_di[6:0];
              ph_d    = '0;
              cnt_d   = '0;
              state_d = bus.cpu_di[7] ? S_HWAIT : S_GDMA;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GDMA: begin
        if (chunk_end_s) begin
          if (blk_q == 7'd0) begin
            state_d = S_IDLE;
            blk_d   = 7'h7F;
          end else begin
            blk_d = blk_q - 7'd1;
          end
        end else begin
          state_d = S_GDMA;
        end
      end

      S_HWAIT: begin
        if (w55_s) begin
          if (bus.cpu_di[7]) begin
            blk_d = bus.cpu_di[6:0];
          end else begin
            state_d = S_IDLE;
          end
        end else if (hblank_s) begin
          state_d = S_HCOPY;
        end else begin
          state_d = S_HWAIT;
        end
      end

      S_HCOPY: begin
        // An abort is held until the byte in flight has been written
        if (chunk_end_s) begin
          abort_d = 1'b0;
          if (blk_q == 7'd0) begin
            state_d = S_IDLE;
            blk_d   = 7'h7F;
          end else begin
            blk_d   = blk_q - 7'd1;
            state_d = abort_now_s ? S_IDLE : S_HWAIT;
          end
        end else if (vwr_s) begin
          abort_d = 1'b0;
          state_d = abort_now_s ? S_IDLE : S_HCOPY;
        end else begin
          abort_d = abort_now_s;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // VRAM DMA state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      blk_q       <= 7'h7F;
      src_q       <= 16'h0000;
      dst_q       <= 13'h0000;
      ph_q        <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      rdpend_q    <= 1'b0;
      data_q      <= 8'h00;
      mode_prev_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      rdpend_q    <= rdpend_d;
      data_q      <= data_d;
      mode_prev_q <= bus.mode;
    end
  end

  assign bus.vram_wr   = vwr_s & ~reset;
  assign bus.vram_addr = vwr_s ? dst_q : 13'h0000;
  assign bus.vram_di   = vwr_s ? (rdpend_q ? bus.src_data : data_q) : 8'h00;
  assign bus.cpu_halt  = busy_s & ~reset;
`else
  logic unused_s;
  assign unused_s      = ^{bus.lcd_on, bus.mode};
  assign vrd_s         = 1'b0;
  assign vsrc_s        = 16'h0000;
  assign hdma_rd_s     = 8'hFF;
  assign bus.vram_wr   = 1'b0;
  assign bus.vram_addr = 13'h0000;
  assign bus.vram_di   = 8'h00;
  assign bus.cpu_halt  = 1'b0;
`endif

  // Source bus: OAM DMA has priority, otherwise the VRAM engine
  assign bus.src_rd   = (oam_active_q | vrd_s) & ~reset;
  assign bus.src_addr = oam_active_q ? {oam_page_q, oam_idx_q} : vsrc_s;

  logic [7:0] cpu_do_s;

  // CPU register read mux
  always_comb begin
    cpu_do_s = 8'hFF;
    if (bus.cpu_sel_reg) begin
      case (bus.cpu_addr)
        8'h46:   cpu_do_s = oam_page_q;
        8'h55:   cpu_do_s = hdma_rd_s;
        default: cpu_do_s = 8'hFF;
      endcase
    end else begin
      cpu_do_s = 8'hFF;
    end
  end

  assign bus.cpu_do = cpu_do_s;

endmodule

// File: tb/tb_video_dma.sv
module tb_video_dma;

  logic clk;
  logic reset;
  video_dma_if bus ();

  video_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Source memory: data one clock after the address
  always @(posedge clk) begin
    if (bus.src_rd) bus.src_data <= mem_val(bus.src_addr);
  end

  // Monitor, sampled on the falling edge
  int          cyc = 0;
  int          oam_cnt = 0;
  int          gap_bad = 0;
  int          last_oam_cyc = 0;
  int          act_cnt = 0;
  int          halt_cnt = 0;
  logic [7:0]  oam_mem [0:255];
  logic [12:0] va [$];
  logic [7:0]  vd [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.oam_wr) begin
      if (oam_cnt > 0 && bus.oam_addr != 8'h00 && (cyc - last_oam_cyc) != 4)
        gap_bad <= gap_bad + 1;
      last_oam_cyc <= cyc;
      oam_cnt <= oam_cnt + 1;
      oam_mem[bus.oam_addr] <= bus.oam_di;
    end
    if (bus.vram_wr) begin
      va.push_back(bus.vram_addr);
      vd.push_back(bus.vram_di);
    end
    if (bus.oam_dma_active) act_cnt <= act_cnt + 1;
    if (bus.cpu_halt) halt_cnt <= halt_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_sel_reg = 1'b1;
    bus.cpu_wr      = 1'b1;
    bus.cpu_addr    = a;
    bus.cpu_di      = d;
    tick();
    bus.cpu_sel_reg = 1'b0;
    bus.cpu_wr      = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    bus.cpu_sel_reg = 1'b1;
    bus.cpu_wr      = 1'b0;
    bus.cpu_addr    = a;
    #1;
    d = bus.cpu_do;
    bus.cpu_sel_reg = 1'b0;
  endtask

  task automatic wait_oam_done(input int budget);
    int n = 0;
    while (bus.oam_dma_active && n < budget) begin
      tick();
      n++;
    end
    check_val("oam_done_in_budget", {31'd0, bus.oam_dma_active}, 32'd0);
  endtask

  task automatic wait_halt_low(input int budget);
    int n = 0;
    while (bus.cpu_halt && n < budget) begin
      tick();
      n++;
    end
    check_val("halt_low_in_budget", {31'd0, bus.cpu_halt}, 32'd0);
  endtask

  // Checks n VRAM writes starting at queue index base against
  // addr0+i (13-bit wrap) and data (lo0+i)^0x5A
  task automatic check_vram(input string tag, input int base, input int n,
                            input logic [12:0] addr0, input logic [7:0] lo0);
    int bad = 0;
    logic [12:0] ea;
    logic [7:0]  ed;
    check_val({tag, "_count"}, va.size() - base, n);
    for (int i = 0; i < n; i++) begin
      ea = addr0 + 13'(i);
      ed = (lo0 + 8'(i)) ^ 8'h5A;
      if (base + i >= va.size()) bad++;
      else if (va[base+i] !== ea || vd[base+i] !== ed) bad++;
    end
    check_val({tag, "_data"}, bad, 0);
  endtask

  logic [7:0] rd;
  int base, h0, o0, a0, bad;
  logic [7:0] exp55 [3];

  initial begin
    reset = 1'b1;
    bus.cpu_sel_reg = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = 8'h00;
    bus.cpu_di = 8'h00;
    bus.lcd_on = 1'b1;
    bus.mode = 2'b11;
    ticks(3);
    reset = 1'b0;
    tick();

    // Reset state
    check_val("rst_oam_active", {31'd0, bus.oam_dma_active}, 32'd0);
    check_val("rst_src_rd", {31'd0, bus.src_rd}, 32'd0);
    check_val("rst_oam_wr", {31'd0, bus.oam_wr}, 32'd0);
    check_val("rst_vram_wr", {31'd0, bus.vram_wr}, 32'd0);
    check_val("rst_cpu_halt", {31'd0, bus.cpu_halt}, 32'd0);
    check_val("rst_src_addr", {16'd0, bus.src_addr}, 32'd0);
    cpu_read(8'h55, rd);
    check_val("rst_reg55", {24'd0, rd}, 32'hFF);
    cpu_read(8'h46, rd);
    check_val("rst_reg46", {24'd0, rd}, 32'h00);

    // OAM DMA from page 0xC1
    a0 = act_cnt;
    o0 = oam_cnt;
    cpu_write(8'h46, 8'hC1);
    check_val("oam_start_active", {31'd0, bus.oam_dma_active}, 32'd1);
    check_val("oam_start_addr", {16'd0, bus.src_addr}, 32'hC100);
    wait_oam_done(1000);
    check_val("oam_active_clocks", act_cnt - a0, 640);
    check_val("oam_pulses", oam_cnt - o0, 160);
    check_val("oam_spacing", gap_bad, 0);
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (oam_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
    end
    check_val("oam_contents", bad, 0);
    cpu_read(8'h46, rd);
    check_val("reg46_page", {24'd0, rd}, 32'hC1);
    cpu_read(8'h51, rd);
    check_val("reg51_read", {24'd0, rd}, 32'hFF);
    cpu_read(8'h00, rd);
    check_val("unmapped_read", {24'd0, rd}, 32'hFF);

`ifdef VIDEO_DMA_HDMA_EN
    // General DMA: 0xD000 -> 0x1800, 32 bytes
    cpu_write(8'h51, 8'hD0);
    cpu_write(8'h52, 8'h0F);
    cpu_write(8'h53, 8'h98);
    cpu_write(8'h54, 8'h00);
    base = va.size();
    h0 = halt_cnt;
    cpu_write(8'h55, 8'h01);
    check_val("gdma_halt_start", {31'd0, bus.cpu_halt}, 32'd1);
    wait_halt_low(200);
    check_vram("gdma", base, 32, 13'h1800, 8'h00);
    check_val("gdma_halt_clocks", halt_cnt - h0, 64);
    cpu_read(8'h55, rd);
    check_val("gdma_reg55", {24'd0, rd}, 32'hFF);

    // HBlank DMA, 3 blocks: 0xD100 -> 0x0800
    exp55[0] = 8'h01;
    exp55[1] = 8'h00;
    exp55[2] = 8'hFF;
    bus.lcd_on = 1'b1;
    bus.mode = 2'b11;
    cpu_write(8'h51, 8'hD1);
    cpu_write(8'h52, 8'h00);
    cpu_write(8'h53, 8'h88);
    cpu_write(8'h54, 8'h00);
    cpu_write(8'h55, 8'h82);
    cpu_read(8'h55, rd);
    check_val("hdma_reg55_start", {24'd0, rd}, 32'h02);
    base = va.size();
    ticks(5);
    check_val("hdma_wait_idle", va.size() - base, 0);
    for (int b = 0; b < 3; b++) begin
      h0 = halt_cnt;
      a0 = va.size();
      bus.mode = 2'b00;
      ticks(40);
      check_val("hdma_block_writes", va.size() - a0, 16);
      check_val("hdma_block_halt", halt_cnt - h0, 32);
      cpu_read(8'h55, rd);
      check_val("hdma_block_reg55", {24'd0, rd}, {24'd0, exp55[b]});
      bus.mode = 2'b11;
      ticks(2);
    end
    check_vram("hdma", base, 48, 13'h0800, 8'h00);

    // HBlank DMA abort after one block
    cpu_write(8'h51, 8'hD2);
    cpu_write(8'h53, 8'h0A);
    cpu_write(8'h55, 8'h83);
    cpu_read(8'h55, rd);
    check_val("abort_reg55_start", {24'd0, rd}, 32'h03);
    bus.mode = 2'b00;
    ticks(40);
    bus.mode = 2'b11;
    ticks(2);
    cpu_read(8'h55, rd);
    check_val("abort_reg55_block", {24'd0, rd}, 32'h02);
    cpu_write(8'h55, 8'h00);
    cpu_read(8'h55, rd);
    check_val("abort_reg55_idle", {24'd0, rd}, 32'h82);
    base = va.size();
    h0 = halt_cnt;
    bus.mode = 2'b00;
    ticks(40);
    bus.mode = 2'b11;
    check_val("abort_no_writes", va.size() - base, 0);
    check_val("abort_no_halt", halt_cnt - h0, 0);

    // Abort mid-block after 8 bytes leaves DST=0x1FF8, then GDMA wraps
    bus.lcd_on = 1'b0;
    cpu_write(8'h51, 8'hD3);
    cpu_write(8'h52, 8'h00);
    cpu_write(8'h53, 8'h1F);
    cpu_write(8'h54, 8'hF0);
    base = va.size();
    cpu_write(8'h55, 8'h80);
    ticks(15);
    cpu_write(8'h55, 8'h00);
    ticks(5);
    check_vram("midabort", base, 8, 13'h1FF0, 8'h00);
    cpu_read(8'h55, rd);
    check_val("midabort_reg55", {24'd0, rd}, 32'h80);
    base = va.size();
    cpu_write(8'h55, 8'h00);
    wait_halt_low(200);
    check_vram("wrap", base, 16, 13'h1FF8, 8'h08);
    if (va.size() >= base + 9) check_val("wrap_addr8", {19'd0, va[base+8]}, 32'h0000);
    else check_val("wrap_addr8_present", va.size(), base + 9);

    // OAM DMA during HCOPY: VRAM bytes stall then resume intact
    cpu_write(8'h51, 8'hD4);
    cpu_write(8'h53, 8'h0C);
    cpu_write(8'h54, 8'h00);
    base = va.size();
    h0 = halt_cnt;
    o0 = oam_cnt;
    cpu_write(8'h55, 8'h80);
    ticks(3);
    cpu_write(8'h46, 8'hC1);
    wait_halt_low(2000);
    check_vram("stall", base, 16, 13'h0C00, 8'h00);
    check_val("stall_halt_clocks", halt_cnt - h0, 672);
    check_val("stall_oam_pulses", oam_cnt - o0, 160);
    check_val("stall_oam_spacing", gap_bad, 0);
    cpu_read(8'h55, rd);
    check_val("stall_reg55", {24'd0, rd}, 32'hFF);
    bus.lcd_on = 1'b1;
`else
    // Without the VRAM engine: 0x51-0x55 are inert
    base = va.size();
    h0 = halt_cnt;
    cpu_write(8'h51, 8'hD0);
    cpu_write(8'h53, 8'h98);
    cpu_write(8'h55, 8'h01);
    ticks(40);
    cpu_write(8'h55, 8'h80);
    bus.lcd_on = 1'b0;
    ticks(40);
    bus.lcd_on = 1'b1;
    check_val("nohdma_vram_wr", va.size() - base, 0);
    check_val("nohdma_halt", halt_cnt - h0, 0);
    cpu_read(8'h55, rd);
    check_val("nohdma_reg55", {24'd0, rd}, 32'hFF);
    cpu_read(8'h53, rd);
    check_val("nohdma_reg53", {24'd0, rd}, 32'hFF);
`endif

    // Reset in the middle of an OAM DMA
    cpu_write(8'h46, 8'hC1);
    ticks(20);
    reset = 1'b1;
    #1;
    o0 = oam_cnt;
    check_val("midrst_oam_wr", {31'd0, bus.oam_wr}, 32'd0);
    ticks(2);
    reset = 1'b0;
    ticks(20);
    check_val("midrst_no_pulses", oam_cnt - o0, 0);
    check_val("midrst_inactive", {31'd0, bus.oam_dma_active}, 32'd0);
    cpu_read(8'h46, rd);
    check_val("midrst_reg46", {24'd0, rd}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_dma.md
VIDEO_DMA -- requirements
Module: video_dma

Interface
REQ-001 Parameter OAM_BYTES, default 160, bytes copied per OAM DMA.
REQ-002 Parameter OAM_CPB, default 4, clocks per OAM DMA byte (minimum 3).
REQ-003 Parameter HDMA_CPB, default 2, clocks per VRAM DMA byte (minimum 2).
REQ-004 Parameter HDMA_BLOCK, default 16, bytes per HBlank block.
REQ-005 clk in 1: clock; all logic on posedge clk.
REQ-006 reset in 1: reset, synchronous, active-high.
REQ-007 cpu_sel_reg in 1, cpu_addr in 8, cpu_wr in 1, cpu_di in 8: CPU I/O register access; cpu_addr is the low byte of 0xFFxx.
REQ-008 cpu_do out 8: read data for the selected register.
REQ-009 lcd_on in 1: LCD enable. mode in 2: LCD mode, where 00 is hblank and 11 is transfer.
REQ-010 src_rd out 1, src_addr out 16, src_data in 8: source bus; data is valid one clock after the address.
REQ-011 oam_wr out 1, oam_addr out 8, oam_di out 8: OAM write port.
REQ-012 vram_wr out 1, vram_addr out 13, vram_di out 8: VRAM write port.
REQ-013 oam_dma_active out 1: OAM DMA running.
REQ-014 cpu_halt out 1: CPU stall request while a VRAM DMA byte transfer runs.

Function
REQ-015 Registers SHALL be: 0x46 OAM DMA page; 0x51 SRC_HI; 0x52 SRC_LO; 0x53 DST_HI; 0x54 DST_LO; 0x55 HDMA control.
- SRC_LO[3:0] and DST_LO[3:0] are forced to 0.
- DST_HI[7:5] is ignored; the destination is 13 bits.
REQ-016 Writing 0x46 SHALL start or restart OAM DMA on the next clock, with byte counter 0 and phase 0.
REQ-017 OAM DMA byte i SHALL drive src_addr={page,i}, oam_addr=i and src_rd=1 for all OAM_CPB clocks.
- oam_wr=1 with oam_di=src_data in phase OAM_CPB-2 only.
REQ-018 OAM DMA SHALL end after byte OAM_BYTES-1.
- With default parameters, oam_dma_active is high for exactly 640 clocks.
REQ-019 VRAM DMA state machine states: IDLE, GDMA, HWAIT, HCOPY.
REQ-020 Writing 0x55 in IDLE with bit7=0 SHALL enter GDMA and copy (di[6:0]+1)*16 bytes.
REQ-021 Writing 0x55 in IDLE with bit7=1 SHALL enter HWAIT with (di[6:0]+1) blocks pending.
REQ-022 HWAIT to HCOPY SHALL occur on a mode 11->00 transition while lcd_on=1.
- If lcd_on=0, the transition occurs immediately.
REQ-023 HCOPY SHALL copy HDMA_BLOCK bytes, then decrement the pending block count.
- It returns to HWAIT, or to IDLE when the count reaches 0.
REQ-024 Each VRAM DMA byte SHALL take HDMA_CPB clocks.
- Phase 0: src_rd=1 with src_addr=SRC.
- Phase HDMA_CPB-1: vram_wr=1, vram_addr=DST, vram_di=src_data.
- After the byte, SRC+=1 (16-bit wrap) and DST+=1 (13-bit wrap, 0x1FFF->0x0000).
REQ-025 cpu_halt SHALL be 1 exactly while the state is GDMA or HCOPY.
REQ-026 Writing 0x55 with bit7=0 in HWAIT or HCOPY SHALL abort.
- In HCOPY the abort takes effect after the current byte completes.
- The state returns to IDLE and the remaining count is kept.
REQ-027 Writing 0x55 with bit7=1 in HWAIT SHALL reload the block count.
- Writes to 0x51-0x54 outside IDLE are ignored.
REQ-028 Reading 0x55 SHALL return {state==IDLE, remaining_blocks-1}.
- After normal completion it reads 0xFF; after an abort it reads {1, remaining-1}.
REQ-029 OAM DMA SHALL own the source bus.
- VRAM DMA byte phases stall (hold phase and counters) while oam_dma_active=1.
- cpu_halt stays asserted during the stall.
REQ-030 Reads of 0x51-0x54 SHALL return 0xFF; 0x46 returns the page; unmapped addresses return 0xFF.

Reset
REQ-031 Reset SHALL set:
- all outputs 0 except cpu_do;
- state IDLE, OAM DMA inactive;
- SRC=0x0000, DST=0x0000, remaining count 0x7F (0x55 reads 0xFF).
REQ-032 Reset mid-transfer SHALL abort immediately and issue no further write strobes.

Configuration
REQ-033 With macro VIDEO_DMA_HDMA_EN defined, REQ-019 to REQ-029 SHALL apply.
REQ-034 Without VIDEO_DMA_HDMA_EN, the block SHALL provide OAM DMA only.
- vram_wr=0 and cpu_halt=0 permanently.
- Writes to 0x51-0x55 are ignored; reads of them return 0xFF.

Verification
REQ-035 Write 0x46=0xC1 with src memory[i]=i^0x5A -> 160 oam_wr pulses, 4 clocks apart; OAM[i]=i^0x5A; oam_dma_active low after 640 clocks.
REQ-036 SRC=0xD000, DST=0x9800, write 0x55=0x01 -> GDMA: 32 vram_wr to 0x1800..0x181F; cpu_halt high 64 clocks; 0x55 then reads 0xFF.
REQ-037 HDMA with 0x55=0x82 and 3 hblank edges -> each edge gives 16 writes in 32 clocks; 0x55 reads 0x01, 0x00, then 0xFF.
REQ-038 HDMA with 0x55=0x83, abort with 0x55=0x00 after 1 block -> IDLE; 0x55 reads 0x82; no further vram_wr.
REQ-039 DST=0x1FF8 with GDMA of 16 bytes -> vram_addr wraps to 0x0000..0x0007.
REQ-040 Write 0x46 during HCOPY -> VRAM DMA stalls 640 clocks, then resumes with no lost or duplicated bytes.
